// File: rtl/scc_isa_pkg.sv
`default_nettype none
// ============================================================================
// Module   : scc_isa_pkg
// Brief    : Shared ISA class/sub-op codes, field positions, legality + encode
// Revision : 1.0
// ============================================================================
package scc_isa_pkg;

    localparam logic [1:0] c_cls_data_imm = 2'b00;
    localparam logic [1:0] c_cls_data_reg = 2'b01;
    localparam logic [1:0] c_cls_ldst     = 2'b10;
    localparam logic [1:0] c_cls_sys      = 2'b11;

    localparam logic [3:0] c_sys_b     = 4'b0000;
    localparam logic [3:0] c_sys_bcond = 4'b0001;
    localparam logic [3:0] c_sys_br    = 4'b0010;
    localparam logic [3:0] c_sys_nop   = 4'b0100;
    localparam logic [3:0] c_sys_halt  = 4'b1000;

    localparam int c_pos_cls  = 30;
    localparam int c_pos_sub  = 25;
    localparam int c_pos_rd   = 22;
    localparam int c_pos_rs1  = 19;
    localparam int c_pos_rs2  = 16;
    localparam int c_pos_cond = 21;
    localparam int c_pos_imm  = 0;

    function automatic logic isa_is_legal(input logic [1:0] cls, input logic [4:0] sub);
        logic ok;
        ok = 1'b0;
        case (cls)
            c_cls_data_imm: ok = (sub <= 5'd5) ||
                                 (sub >= 5'd17 && sub <= 5'd21) ||
                                 (sub >= 5'd25 && sub <= 5'd29);
            c_cls_data_reg: ok = (sub >= 5'd17 && sub <= 5'd22) ||
                                 (sub >= 5'd25 && sub <= 5'd29);
            c_cls_ldst:     ok = 1'b1;
            default:        ok = (sub[3:0] == c_sys_b)   || (sub[3:0] == c_sys_bcond) ||
                                 (sub[3:0] == c_sys_br)  || (sub[3:0] == c_sys_nop)   ||
                                 (sub[3:0] == c_sys_halt);
        endcase
        return ok;
    endfunction

    function automatic logic [31:0] isa_encode(
        input logic [1:0]  cls,
        input logic [4:0]  sub,
        input logic [2:0]  rd,
        input logic [2:0]  rs1,
        input logic [2:0]  rs2,
        input logic [3:0]  cond,
        input logic [15:0] imm
    );
        logic [31:0] word;
        word = '0;
        word[c_pos_cls +: 2] = cls;
        word[c_pos_rd  +: 3] = rd;
        word[c_pos_rs1 +: 3] = rs1;
        case (cls)
            c_cls_data_imm: begin
                word[c_pos_sub +: 5]  = sub;
                word[c_pos_imm +: 16] = imm;
            end
            c_cls_data_reg: begin
                word[c_pos_sub +: 5] = sub;
                word[c_pos_rs2 +: 3] = rs2;
            end
            c_cls_ldst: begin
                word[c_pos_sub]       = sub[0];
                word[c_pos_imm +: 16] = imm;
            end
            default: begin
                word[c_pos_sub +: 4]  = sub[3:0];
                word[c_pos_imm +: 16] = imm;
                // Bcond reuses the rd/rs1 slots for its condition code
                if (sub[3:0] == c_sys_bcond) begin
                    word[c_pos_rs1 +: 6]  = '0;
                    word[c_pos_cond +: 4] = cond;
                end
            end
        endcase
        return word;
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_fifo.sv
`default_nettype none
// ============================================================================
// Module   : instr_fifo
// Brief    : Synchronous DEPTH x WIDTH FIFO with full/empty flags
// Revision : 1.0
// ============================================================================
module instr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int c_aw = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw:0]    r_wr_ptr;
    logic [c_aw:0]    r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Extra pointer MSB distinguishes full from empty when indices match
    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                       (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign pop_data  = r_mem[r_rd_ptr[c_aw-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + (c_aw+1)'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (c_aw+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[c_aw-1:0]] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : instr_encoder
// Brief    : Encodes field requests into 32-bit words and streams them to imem
// Revision : 1.0
// ============================================================================
module instr_encoder
    import scc_isa_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [1:0]        op_class,
    input  logic [4:0]        sub_op,
    input  logic [2:0]        rd,
    input  logic [2:0]        rs1,
    input  logic [2:0]        rs2,
    input  logic [3:0]        cond,
    input  logic [15:0]       imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    input  logic              mem_ready,
    output logic              done,
    output logic              wrapped,
    output logic              err_illegal
);
    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_run   = 2'd1;
    localparam logic [1:0] c_st_drain = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_wrapped;
    logic              r_err;
    logic              w_full;
    logic              w_empty;
    logic              w_legal;
    logic              w_halt;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;
    logic              w_start;
    logic [31:0]       w_word;

    assign w_legal  = isa_is_legal(op_class, sub_op);
    assign w_halt   = (op_class == c_cls_sys) && (sub_op[3:0] == c_sys_halt);
    assign w_word   = isa_encode(op_class, sub_op, rd, rs1, rs2, cond, imm);
    assign w_accept = op_valid && op_ready;
    // Illegal requests complete the handshake but never enter the FIFO
    assign w_push   = w_accept && w_legal;
    assign w_pop    = imem_we && mem_ready;
    assign w_start  = start && ((r_state == c_st_idle) || (r_state == c_st_done));

    assign op_ready    = (r_state == c_st_run) && !w_full;
    assign imem_we     = ((r_state == c_st_run) || (r_state == c_st_drain)) && !w_empty;
    assign imem_addr   = r_addr;
    assign done        = (r_state == c_st_done);
    assign wrapped     = r_wrapped;
    assign err_illegal = r_err;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle,
            c_st_done:  if (w_start) w_state_nxt = c_st_run;
            c_st_run:   if (w_push && w_halt) w_state_nxt = c_st_drain;
            c_st_drain: if (w_empty) w_state_nxt = c_st_done;
            default:    w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_st_idle;
            r_addr    <= '0;
            r_wrapped <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_addr    <= base_addr;
                r_wrapped <= 1'b0;
                r_err     <= 1'b0;
            end else begin
                if (w_pop) begin
                    r_addr <= r_addr + ADDR_W'(1);
                    if (&r_addr) r_wrapped <= 1'b1;
                end
                if (w_accept && !w_legal) r_err <= 1'b1;
            end
        end
    end

    instr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .push_data (w_word),
        .pop       (w_pop),
        .pop_data  (imem_wdata),
        .full      (w_full),
        .empty     (w_empty)
    );

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_encoder
// Brief    : Directed stimulus with a transaction-level scoreboard model
// Revision : 1.0
// ============================================================================
module tb_instr_encoder;
    localparam int ADDR_W     = 10;
    localparam int FIFO_DEPTH = 4;
    localparam int c_addr_max = (1 << ADDR_W) - 1;
    localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_DONE = 3;

    typedef struct packed { int cls; int sub; int rd; int rs1; int rs2; int cond; int imm; } op_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic              op_valid = 1'b0;
    logic              op_ready;
    logic [1:0]        op_class = '0;
    logic [4:0]        sub_op = '0;
    logic [2:0]        rd = '0;
    logic [2:0]        rs1 = '0;
    logic [2:0]        rs2 = '0;
    logic [3:0]        cond = '0;
    logic [15:0]       imm = '0;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              mem_ready = 1'b1;
    logic              done;
    logic              wrapped;
    logic              err_illegal;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    int m_mode = M_IDLE;
    int m_addr = 0;
    bit m_wrapped = 0;
    bit m_err = 0;

    instr_encoder #(.ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .op_valid(op_valid), .op_ready(op_ready), .op_class(op_class), .sub_op(sub_op),
        .rd(rd), .rs1(rs1), .rs2(rs2), .cond(cond), .imm(imm),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .mem_ready(mem_ready), .done(done), .wrapped(wrapped), .err_illegal(err_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Word layout built from field arithmetic rather than part selects
    function automatic logic [31:0] model_word(input op_t o);
        logic [31:0] w;
        w = (o.cls << 30) | (o.rd << 22) | (o.rs1 << 19);
        if (o.cls == 0)      w = w | (o.sub << 25) | o.imm;
        else if (o.cls == 1) w = w | (o.sub << 25) | (o.rs2 << 16);
        else if (o.cls == 2) w = w | ((o.sub % 2) << 25) | o.imm;
        else begin
            w = w | ((o.sub % 16) << 25) | o.imm;
            if (o.sub % 16 == 1) w = (w & ~32'h01F8_0000) | (o.cond << 21);
        end
        return w;
    endfunction

    function automatic bit model_legal(input op_t o);
        case (o.cls)
            0:       return o.sub inside {[0:5], [17:21], [25:29]};
            1:       return o.sub inside {[17:22], [25:29]};
            2:       return 1'b1;
            default: return (o.sub % 16) inside {0, 1, 2, 4, 8};
        endcase
    endfunction

    function automatic op_t mk(input int cls, sub, r_d, r_s1, r_s2, cnd, im);
        op_t o;
        o.cls = cls; o.sub = sub; o.rd = r_d; o.rs1 = r_s1; o.rs2 = r_s2; o.cond = cnd; o.imm = im;
        return o;
    endfunction

    always @(negedge clk) begin : p_compare
        int  prev_mode;
        bit  was_empty;
        op_t o;
        if (!rst_n) begin
            chk("rst_imem_we", imem_we, 0);
            chk("rst_op_ready", op_ready, 0);
            chk("rst_done", done, 0);
            chk("rst_wrapped", wrapped, 0);
            chk("rst_err", err_illegal, 0);
            chk("rst_addr", imem_addr, 0);
            exp_q.delete();
            m_mode = M_IDLE; m_addr = 0; m_wrapped = 0; m_err = 0;
        end else begin
            chk("op_ready", op_ready, (m_mode == M_RUN) && (exp_q.size() < FIFO_DEPTH));
            chk("imem_we", imem_we, ((m_mode == M_RUN) || (m_mode == M_DRAIN)) && (exp_q.size() > 0));
            chk("done", done, m_mode == M_DONE);
            chk("wrapped", wrapped, m_wrapped);
            chk("err_illegal", err_illegal, m_err);
            prev_mode = m_mode;
            was_empty = (exp_q.size() == 0);
            if (imem_we && mem_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_write: addr=%h data=%h required=no write", imem_addr, imem_wdata);
                end else begin
                    chk("wr_addr", imem_addr, m_addr);
                    chk("wr_data", imem_wdata, exp_q.pop_front());
                    if (m_addr == c_addr_max) m_wrapped = 1;
                    m_addr = (m_addr + 1) % (c_addr_max + 1);
                end
            end
            if (op_valid && op_ready) begin
                o = mk(int'(op_class), int'(sub_op), int'(rd), int'(rs1), int'(rs2), int'(cond), int'(imm));
                if (model_legal(o)) begin
                    exp_q.push_back(model_word(o));
                    if (o.cls == 3 && o.sub % 16 == 8) m_mode = M_DRAIN;
                end else m_err = 1;
            end
            if (prev_mode == M_DRAIN && was_empty) m_mode = M_DONE;
            if (start && (prev_mode == M_IDLE || prev_mode == M_DONE)) begin
                m_mode = M_RUN; m_addr = int'(base_addr); m_wrapped = 0; m_err = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic drive_op(input op_t o);
        op_class = 2'(o.cls); sub_op = 5'(o.sub); rd = 3'(o.rd); rs1 = 3'(o.rs1);
        rs2 = 3'(o.rs2); cond = 4'(o.cond); imm = 16'(o.imm);
    endtask

    task automatic start_prog(input logic [ADDR_W-1:0] b);
        start = 1'b1; base_addr = b;
        tick();
        start = 1'b0;
    endtask

    task automatic send_op(input op_t o);
        bit got = 0;
        drive_op(o); op_valid = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = op_ready;
        end
        tick();
        op_valid = 1'b0;
        chk("op_accept", got, 1);
    endtask

    task automatic wait_done();
        bit seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            seen = done;
        end
        chk("wait_done", seen, 1);
        tick();
    endtask

    task automatic stream(input op_t ops[6], inout int idx, input int budget);
        bit acc;
        for (int c = 0; c < budget && idx < 6; c++) begin
            @(negedge clk); acc = op_valid && op_ready;
            tick();
            if (acc) begin
                idx++;
                if (idx < 6) drive_op(ops[idx]); else op_valid = 1'b0;
            end
        end
    endtask

    initial begin
        op_t halt, st_ops[6];
        int  idx;
        halt = mk(3, 8, 0, 0, 0, 0, 0);
        st_ops[0] = mk(2, 1, 4, 5, 0, 0, 'h0020);
        st_ops[1] = mk(0, 5, 7, 1, 0, 0, 'h1234);
        st_ops[2] = mk(1, 22, 2, 3, 6, 0, 0);
        st_ops[3] = mk(3, 4, 0, 0, 0, 0, 0);
        st_ops[4] = mk(3, 2, 0, 6, 0, 0, 0);
        st_ops[5] = mk(0, 29, 1, 1, 0, 0, 'hBEEF);

        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk); #1;
        @(negedge clk);
        chk("reset_we", imem_we, 0);
        chk("reset_ready", op_ready, 0);
        chk("reset_done", done, 0);
        chk("reset_addr", imem_addr, 0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ready", op_ready, 0);
        chk("pin_addi", model_word(mk(0, 17, 3, 2, 0, 0, 5)), 32'h22D0_0005);
        chk("pin_xor", model_word(mk(1, 21, 1, 4, 7, 0, 0)), 32'h6A67_0000);
        chk("pin_bcond", model_word(mk(3, 1, 0, 0, 0, 5, 'hFFF0)), 32'hC2A0_FFF0);
        chk("pin_halt", model_word(halt), 32'hD000_0000);
        chk("pin_illegal", model_legal(mk(0, 22, 0, 0, 0, 0, 0)), 0);
        tick();

        start_prog(10'h010);
        send_op(mk(0, 17, 3, 2, 0, 0, 'h0005));
        @(negedge clk);
        chk("addi_we", imem_we, 1);
        chk("addi_addr", imem_addr, 10'h010);
        chk("addi_data", imem_wdata, 32'h22D0_0005);
        tick();
        send_op(mk(1, 21, 1, 4, 7, 0, 0));
        @(negedge clk);
        chk("xor_addr", imem_addr, 10'h011);
        chk("xor_data", imem_wdata, 32'h6A67_0000);
        tick();
        start_prog(10'h200);
        send_op(mk(3, 1, 0, 0, 0, 5, 'hFFF0));
        @(negedge clk);
        chk("bcond_addr", imem_addr, 10'h012);
        chk("bcond_data", imem_wdata, 32'hC2A0_FFF0);
        tick();
        send_op(mk(0, 22, 1, 1, 0, 0, 'h00FF));
        @(negedge clk);
        chk("illegal_err", err_illegal, 1);
        chk("illegal_no_we", imem_we, 0);
        tick();
        send_op(mk(2, 0, 1, 2, 0, 0, 'h0010));
        @(negedge clk);
        chk("after_illegal_addr", imem_addr, 10'h013);
        chk("after_illegal_data", imem_wdata, 32'h8050_0010);
        tick(); tick();

        mem_ready = 1'b0;
        idx = 0;
        drive_op(st_ops[0]); op_valid = 1'b1;
        stream(st_ops, idx, 12);
        chk("stall_accepted", idx, 4);
        chk("stall_ready", op_ready, 0);
        mem_ready = 1'b1;
        stream(st_ops, idx, 30);
        op_valid = 1'b0;
        chk("stall_all", idx, 6);
        send_op(halt);
        wait_done();
        chk("prog1_drained", exp_q.size(), 0);

        start_prog(10'h3FE);
        @(negedge clk);
        chk("restart_err", err_illegal, 0);
        chk("restart_done", done, 0);
        tick();
        send_op(mk(2, 1, 5, 6, 0, 0, 'h000C));
        send_op(mk(0, 0, 2, 2, 0, 0, 'hABCD));
        send_op(mk(3, 0, 0, 0, 0, 0, 'h0100));
        tick(); tick();
        @(negedge clk);
        chk("wrap_flag", wrapped, 1);
        tick();
        send_op(halt);
        @(negedge clk);
        chk("halt_we", imem_we, 1);
        chk("halt_addr", imem_addr, 10'h001);
        chk("halt_data", imem_wdata, 32'hD000_0000);
        tick();
        wait_done();

        start_prog(10'h100);
        mem_ready = 1'b0;
        send_op(mk(0, 1, 1, 1, 0, 0, 'h0001));
        send_op(mk(1, 17, 2, 2, 2, 0, 0));
        send_op(halt);
        @(negedge clk);
        chk("drain_we", imem_we, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_we", imem_we, 0);
        chk("async_ready", op_ready, 0);
        chk("async_addr", imem_addr, 0);
        tick(); tick();
        rst_n = 1'b1; mem_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_we", imem_we, 0);
        chk("post_rst_ready", op_ready, 0);
        chk("post_rst_done", done, 0);
        tick();
        start_prog(10'h020);
        send_op(mk(2, 1, 3, 3, 0, 0, 'h0004));
        @(negedge clk);
        chk("fresh_addr", imem_addr, 10'h020);
        chk("fresh_data", imem_wdata, 32'h82D8_0004);
        tick(); tick();
        chk("final_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
